mips32_mem_arbiter: RTL and testbench

Single-port memory arbiter for the MIPS32 pipelined core. It shares one synchronous word-addressed memory among three requesters: instruction fetch (IF), the MEM-stage load/store unit (D), and a debug/program-loader port (DBG). It issues at most one access per cycle and returns read data after a fixed latency. It prevents IF starvation, and it gives the debug port an exclusive lock for loading programs while the core is parked.

---
 rtl/mips32_mem_arbiter_if.sv | 73 +++++++
 rtl/mips32_mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if
// ---------------------
// Bundles the request/response buses of the three memory requesters
// (instruction fetch, data, debug), the single-port memory command bus
// and the core stall line shared by mips32_mem_arbiter.
//
// Modports:
//   slave  - the arbiter's view. Requests and mem_rdata come in. Grants,
//            read returns, the memory command and stall_if go out.
//   master - the surrounding system's view: requesters, memory and core.
//
// Parameters: ADDR_W (word-address width), DATA_W (data width).
interface mips32_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  // Instruction fetch port (read only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // MEM-stage load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // Debug / program-loader port
  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              dbg_locked;
  logic [DATA_W-1:0] dbg_rdata;
  // Memory command and return
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Core stall
  logic              stall_if;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output dbg_gnt, dbg_rvalid, dbg_locked, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_locked, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter
// ------------------
// Shares one synchronous, word-addressed, single-port memory among the
// instruction fetch (IF), load/store (D) and debug (DBG) requesters.
// Grants are combinational, with at most one per cycle. Read data returns
// one cycle after the grant. IF is promoted over D after STARVE_MAX
// consecutive denials. DBG can take an exclusive lock for program loading.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset
//   bus - mips32_mem_arbiter_if.slave (requesters, memory command, stall_if)
//
// Build option: define MIPS32_MEM_ARB_DEBUG_EN to enable the DBG port and
// the lock FSM. Without it, the dbg_* inputs are ignored, the dbg_* outputs
// are 0, and arbitration is D > IF with starvation promotion.
module mips32_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mips32_mem_arbiter_if.slave     bus
);

`ifdef MIPS32_MEM_ARB_DEBUG_EN
  localparam logic DBG_EN = 1'b1;
`else
  localparam logic DBG_EN = 1'b0;
`endif

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] OWN_IF     = 2'd0;
  localparam logic [1:0] OWN_D      = 2'd1;
  localparam logic [1:0] OWN_DBG    = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOCK_PEND = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic [1:0]  rd_owner_q, rd_owner_d;

  logic              dbg_req_s, dbg_lock_s;
  logic              if_gnt_s, d_gnt_s, dbg_gnt_s;
  logic              mem_en_s, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              if_rv_s, d_rv_s, dbg_rv_s;

  // Without the debug build the DBG inputs are forced inactive, so the FSM never leaves RUN.
  assign dbg_req_s  = DBG_EN & bus.dbg_req;
  assign dbg_lock_s = DBG_EN & bus.dbg_lock;

  // Grant selection: one winner per cycle, nothing granted while in reset or LOCK_PEND.
  always_comb begin
    if_gnt_s  = 1'b0;
    d_gnt_s   = 1'b0;
    dbg_gnt_s = 1'b0;
    if (rst) begin
      dbg_gnt_s = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dbg_req_s) begin
            dbg_gnt_s = 1'b1;
          end else if (bus.if_req && (starve_cnt_q == STARVE_LIM)) begin
            if_gnt_s = 1'b1;  // starved fetch overtakes D
          end else if (bus.d_req) begin
            d_gnt_s = 1'b1;
          end else if (bus.if_req) begin
            if_gnt_s = 1'b1;
          end else begin
            dbg_gnt_s = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (dbg_req_s) begin
            dbg_gnt_s = 1'b1;
          end else begin
            dbg_gnt_s = 1'b0;
          end
        end
        default: begin
          dbg_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Memory command mux driven from whichever requester holds the grant.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (dbg_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.dbg_we;
      mem_addr_s  = bus.dbg_addr;
      mem_wdata_s = bus.dbg_wdata;
    end else if (d_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.d_we;
      mem_addr_s  = bus.d_addr;
      mem_wdata_s = bus.d_wdata;
    end else if (if_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = 1'b0;
      mem_addr_s  = bus.if_addr;
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Next-state logic for the starvation counter, read tracker and lock FSM.
  always_comb begin
    starve_cnt_d = 4'd0;
    rd_valid_d   = mem_en_s & ~mem_we_s;
    rd_owner_d   = rd_owner_q;
    state_d      = state_q;

    if (bus.if_req && !if_gnt_s) begin
      if (starve_cnt_q >= STARVE_LIM) begin
        starve_cnt_d = STARVE_LIM;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end

    if (dbg_gnt_s) begin
      rd_owner_d = OWN_DBG;
    end else if (d_gnt_s) begin
      rd_owner_d = OWN_D;
    end else if (if_gnt_s) begin
      rd_owner_d = OWN_IF;
    end else begin
      rd_owner_d = rd_owner_q;
    end

    case (state_q)
      ST_RUN: begin
        if (dbg_lock_s) begin
          state_d = ST_LOCK_PEND;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOCK_PEND: begin
        // Lock is only granted once the last read has been returned.
        if (!dbg_lock_s) begin
          state_d = ST_RUN;
        end else if (!rd_valid_q) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOCK_PEND;
        end
      end
      ST_LOCKED: begin
        if (!dbg_lock_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers. Reset also drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      starve_cnt_q <= 4'd0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= OWN_IF;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read-return steering. Only the owner of the previous cycle's read sees data.
  always_comb begin
    if_rv_s  = 1'b0;
    d_rv_s   = 1'b0;
    dbg_rv_s = 1'b0;
    if (!rst && rd_valid_q) begin
      if_rv_s  = (rd_owner_q == OWN_IF);
      d_rv_s   = (rd_owner_q == OWN_D);
      dbg_rv_s = (rd_owner_q == OWN_DBG);
    end else begin
      if_rv_s  = 1'b0;
    end
  end

  assign bus.if_gnt     = if_gnt_s;
  assign bus.d_gnt      = d_gnt_s;
  assign bus.dbg_gnt    = dbg_gnt_s;
  assign bus.mem_en     = mem_en_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.if_rvalid  = if_rv_s;
  assign bus.d_rvalid   = d_rv_s;
  assign bus.dbg_rvalid = dbg_rv_s;
  assign bus.if_rdata   = if_rv_s  ? bus.mem_rdata : '0;
  assign bus.d_rdata    = d_rv_s   ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = dbg_rv_s ? bus.mem_rdata : '0;
  assign bus.dbg_locked = DBG_EN & ~rst & (state_q == ST_LOCKED);
  assign bus.stall_if   = (bus.if_req & ~if_gnt_s) | (~rst & (state_q != ST_RUN));

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
module tb_mips32_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;
`ifdef MIPS32_MEM_ARB_DEBUG_EN
  localparam bit DBG_ON = 1'b1;
`else
  localparam bit DBG_ON = 1'b0;
`endif
  localparam int W_NONE = -1, W_IF = 0, W_D = 1, W_DBG = 2;
  localparam int M_RUN = 0, M_PEND = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips32_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory attached to the DUT's command bus
  logic [DATA_W-1:0] emem [1024];
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      emem[bus.mem_addr] <= bus.mem_wdata;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= emem[bus.mem_addr];
    end
  end

  // Reference model state
  logic [DATA_W-1:0] mref [1024];
  int m_mode = M_RUN;
  int m_starve = 0;
  int m_rv_who = W_NONE;
  logic [DATA_W-1:0] m_rv_data = '0;
  int last_win;

  int n_cmp = 0;
  int n_err = 0;

  // Snapshot of outputs from the most recent step
  logic [2:0] s_gnt, s_rv;
  logic [DATA_W-1:0] s_if_rd, s_d_rd, s_g_rd;
  logic s_stall, s_lock, s_mem_en;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: inputs are already applied; sample, compare with the model, advance the model.
  task automatic step();
    int win;
    bit ireq, dreq, greq, glock, we_s;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [2:0] exp_rv;
    #1;
    ireq  = bus.if_req;
    dreq  = bus.d_req;
    greq  = DBG_ON && bus.dbg_req;
    glock = DBG_ON && bus.dbg_lock;

    win = W_NONE;
    if (!rst) begin
      if (m_mode == M_RUN) begin
        if (greq) win = W_DBG;
        else if (ireq && m_starve >= STARVE_MAX) win = W_IF;
        else if (dreq) win = W_D;
        else if (ireq) win = W_IF;
      end else if (m_mode == M_LOCKED && greq) begin
        win = W_DBG;
      end
    end
    we_s = 1'b0; a = '0; wd = '0;
    if (win == W_IF) begin a = bus.if_addr; end
    if (win == W_D) begin we_s = bus.d_we; a = bus.d_addr; wd = bus.d_wdata; end
    if (win == W_DBG) begin we_s = bus.dbg_we; a = bus.dbg_addr; wd = bus.dbg_wdata; end

    chk("gnt", {bus.dbg_gnt, bus.d_gnt, bus.if_gnt}, {win == W_DBG, win == W_D, win == W_IF});
    chk("mem_en", bus.mem_en, win != W_NONE);
    if (win != W_NONE) chk("mem_cmd", {bus.mem_we, bus.mem_addr}, {we_s, a});
    if (win != W_NONE && we_s) chk("mem_wdata", bus.mem_wdata, wd);

    exp_rv = 3'b000;
    if (!rst && m_rv_who != W_NONE) exp_rv[m_rv_who] = 1'b1;
    chk("rvalid", {bus.dbg_rvalid, bus.d_rvalid, bus.if_rvalid}, exp_rv);
    chk("if_rdata", bus.if_rdata, exp_rv[0] ? m_rv_data : '0);
    chk("d_rdata", bus.d_rdata, exp_rv[1] ? m_rv_data : '0);
    chk("dbg_rdata", bus.dbg_rdata, exp_rv[2] ? m_rv_data : '0);
    chk("stall_if", bus.stall_if, (ireq && win != W_IF) || (!rst && m_mode != M_RUN));
    chk("dbg_locked", bus.dbg_locked, !rst && m_mode == M_LOCKED);

    s_gnt = {bus.dbg_gnt, bus.d_gnt, bus.if_gnt};
    s_rv = {bus.dbg_rvalid, bus.d_rvalid, bus.if_rvalid};
    s_if_rd = bus.if_rdata; s_d_rd = bus.d_rdata; s_g_rd = bus.dbg_rdata;
    s_stall = bus.stall_if; s_lock = bus.dbg_locked; s_mem_en = bus.mem_en;

    if (rst) begin
      m_mode = M_RUN; m_starve = 0; m_rv_who = W_NONE;
    end else begin
      m_starve = (ireq && win != W_IF) ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
      case (m_mode)
        M_RUN:   if (glock) m_mode = M_PEND;
        M_PEND:  if (!glock) m_mode = M_RUN; else if (m_rv_who == W_NONE) m_mode = M_LOCKED;
        default: if (!glock) m_mode = M_RUN;
      endcase
      if (win != W_NONE && !we_s) begin
        m_rv_who = win; m_rv_data = mref[a];
      end else begin
        m_rv_who = W_NONE;
      end
      if (win != W_NONE && we_s) mref[a] = wd;
    end
    last_win = win;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0;
    bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  initial begin
    bit ip, dp, gp;
    string pat;
    for (int i = 0; i < 1024; i++) begin
      emem[i] = 32'h1000_0000 + 32'(i * 7);
      mref[i] = 32'h1000_0000 + 32'(i * 7);
    end
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_idle", {s_gnt, s_rv, s_stall, s_lock, s_mem_en}, 9'd0);

    // Reset with a read in flight
    bus.if_req = 1'b1; bus.if_addr = 10'd5;
    step();
    chk("rst_mid_gnt", s_gnt, 3'b001);
    bus.if_req = 1'b0; rst = 1'b1;
    step();
    chk("rst_mid_rvalid", s_rv, 3'b000);
    rst = 1'b0;
    step();
    chk("rst_after", {s_gnt, s_rv, s_if_rd}, 38'd0);

    // IF/D contention
    bus.if_req = 1'b1; bus.if_addr = 10'd20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd21;
    pat = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) begin
      step();
      chk("contend_gnt", s_gnt, (pat[i] == "D") ? 3'b010 : 3'b001);
      chk("contend_stall", s_stall, pat[i] == "D");
    end
    idle_inputs();
    step();

    // Write then read
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd10; bus.d_wdata = 32'hDEADBEEF;
    step();
    chk("wr_gnt", s_gnt, 3'b010);
    bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'd10;
    step();
    chk("rd_gnt", s_gnt, 3'b001);
    bus.if_req = 1'b0;
    step();
    chk("rd_rvalid", s_rv, 3'b001);
    chk("rd_data", s_if_rd, 32'hDEADBEEF);

`ifdef MIPS32_MEM_ARB_DEBUG_EN
    // Lock requested together with a D read
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd10; bus.dbg_lock = 1'b1;
    step();
    chk("lock_d_gnt", s_gnt, 3'b010);
    bus.d_addr = 10'd11; bus.if_req = 1'b1; bus.if_addr = 10'd3;
    step();
    chk("lock_d_rvalid", {s_rv, s_d_rd}, {3'b010, 32'hDEADBEEF});
    chk("lock_pend_a", {s_gnt, s_lock}, 4'd0);
    step();
    chk("lock_pend_b", {s_gnt, s_lock}, 4'd0);
    step();
    chk("locked", {s_gnt, s_lock}, 4'b0001);
    // Program load while locked
    for (int i = 0; i < 4; i++) begin
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 10'(i); bus.dbg_wdata = 32'(i + 1);
      step();
      chk("dbg_wr_gnt", s_gnt, 3'b100);
    end
    for (int i = 0; i < 5; i++) begin
      bus.dbg_req = (i < 4); bus.dbg_we = 1'b0; bus.dbg_addr = 10'(i);
      step();
      chk("dbg_rd_gnt", s_gnt, (i < 4) ? 3'b100 : 3'b000);
      if (i > 0) chk("dbg_load", {s_rv, s_g_rd}, {3'b100, 32'(i)});
    end
    bus.dbg_lock = 1'b0;
    step();
    chk("unlock_edge", {s_gnt, s_lock}, 4'b0001);
    step();
    chk("unlock_if_first", s_gnt, 3'b001);
    bus.if_req = 1'b0;
    step();
    chk("unlock_d_next", s_gnt, 3'b010);
    idle_inputs();
    step();
`else
    // Debug port absent: DBG inputs must have no effect
    bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1; bus.dbg_addr = 10'd1;
    bus.if_req = 1'b1; bus.if_addr = 10'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nodbg_if_gnt", s_gnt, 3'b001);
      chk("nodbg_out", {s_rv[2], s_g_rd, s_lock}, 34'd0);
    end
    idle_inputs();
    step();
`endif

    // Randomized traffic against the model
    ip = 1'b0; dp = 1'b0; gp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin
        ip = 1'b1; bus.if_addr = 10'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 99) < 50) begin
        dp = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 10'($urandom_range(0, 15)); bus.d_wdata = $urandom;
      end
      if (!gp && $urandom_range(0, 99) < 20) begin
        gp = 1'b1; bus.dbg_we = 1'($urandom_range(0, 1));
        bus.dbg_addr = 10'($urandom_range(0, 15)); bus.dbg_wdata = $urandom;
      end
      bus.if_req = ip; bus.d_req = dp; bus.dbg_req = gp;
      if ($urandom_range(0, 99) < 4) bus.dbg_lock = ~bus.dbg_lock;
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (last_win == W_IF) ip = 1'b0;
      if (last_win == W_D) dp = 1'b0;
      if (last_win == W_DBG) gp = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
